// File: rtl/wb_regfile_fwd.sv
// Writeback stage: commits EX/WB results into an 8-entry register file with R0 hardwired to zero.
// Provides write-through ID read ports, EX operand forwarding and a committed-writeback counter.
module wb_regfile_fwd #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              EX_WB_RegWrite,
  input  logic [ADDR_W-1:0] EX_WB_Write_Reg_Num,
  input  logic [DATA_W-1:0] EX_WB_ALUResult,
  input  logic [ADDR_W-1:0] Read_Reg_Num1,
  input  logic [ADDR_W-1:0] Read_Reg_Num2,
  output logic [DATA_W-1:0] Read_Data1,
  output logic [DATA_W-1:0] Read_Data2,
  input  logic [ADDR_W-1:0] ID_EX_Rs1,
  input  logic [ADDR_W-1:0] ID_EX_Rs2,
  input  logic [DATA_W-1:0] ID_EX_Data1,
  input  logic [DATA_W-1:0] ID_EX_Data2,
  output logic [DATA_W-1:0] EX_Operand1,
  output logic [DATA_W-1:0] EX_Operand2,
  output logic [CNT_W-1:0]  WB_Count
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic              commit;

  // A write to R0 is not a commit: it neither updates the array nor the counter.
  assign commit = EX_WB_RegWrite && (EX_WB_Write_Reg_Num != '0);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      WB_Count <= '0;
    end else if (commit) begin
      regs[EX_WB_Write_Reg_Num] <= EX_WB_ALUResult;
      WB_Count                  <= WB_Count + CNT_W'(1);
    end
  end

  // ID read ports: commit is only true for nonzero destinations, so R0 never bypasses.
  always_comb begin
    Read_Data1 = '0;
    if (Read_Reg_Num1 != '0) begin
      if (commit && (EX_WB_Write_Reg_Num == Read_Reg_Num1)) Read_Data1 = EX_WB_ALUResult;
      else                                                  Read_Data1 = regs[Read_Reg_Num1];
    end
  end

  always_comb begin
    Read_Data2 = '0;
    if (Read_Reg_Num2 != '0) begin
      if (commit && (EX_WB_Write_Reg_Num == Read_Reg_Num2)) Read_Data2 = EX_WB_ALUResult;
      else                                                  Read_Data2 = regs[Read_Reg_Num2];
    end
  end

  // EX forwarding: each operand independently takes the WB value on a register match.
  assign EX_Operand1 = (commit && (EX_WB_Write_Reg_Num == ID_EX_Rs1)) ? EX_WB_ALUResult : ID_EX_Data1;
  assign EX_Operand2 = (commit && (EX_WB_Write_Reg_Num == ID_EX_Rs2)) ? EX_WB_ALUResult : ID_EX_Data2;

endmodule

// File: tb/tb_wb_regfile_fwd.sv
// Directed bench for wb_regfile_fwd: commit, bypass, R0, forwarding, async reset and counter wrap.
module tb_wb_regfile_fwd;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       EX_WB_RegWrite;
  logic [2:0] EX_WB_Write_Reg_Num;
  logic [7:0] EX_WB_ALUResult;
  logic [2:0] Read_Reg_Num1, Read_Reg_Num2;
  logic [7:0] Read_Data1, Read_Data2;
  logic [2:0] ID_EX_Rs1, ID_EX_Rs2;
  logic [7:0] ID_EX_Data1, ID_EX_Data2;
  logic [7:0] EX_Operand1, EX_Operand2;
  logic [15:0] WB_Count;
  logic [7:0] rd1_w, rd2_w, op1_w, op2_w;
  logic [3:0] wb_count_w;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 Clk = ~Clk;

  wb_regfile_fwd u_dut (
    .Clk(Clk), .Reset(Reset),
    .EX_WB_RegWrite(EX_WB_RegWrite), .EX_WB_Write_Reg_Num(EX_WB_Write_Reg_Num),
    .EX_WB_ALUResult(EX_WB_ALUResult),
    .Read_Reg_Num1(Read_Reg_Num1), .Read_Reg_Num2(Read_Reg_Num2),
    .Read_Data1(Read_Data1), .Read_Data2(Read_Data2),
    .ID_EX_Rs1(ID_EX_Rs1), .ID_EX_Rs2(ID_EX_Rs2),
    .ID_EX_Data1(ID_EX_Data1), .ID_EX_Data2(ID_EX_Data2),
    .EX_Operand1(EX_Operand1), .EX_Operand2(EX_Operand2),
    .WB_Count(WB_Count)
  );

  // Narrow-counter instance sharing the same stimulus, for the wrap check.
  wb_regfile_fwd #(.DATA_W(8), .ADDR_W(3), .CNT_W(4)) u_dut_w (
    .Clk(Clk), .Reset(Reset),
    .EX_WB_RegWrite(EX_WB_RegWrite), .EX_WB_Write_Reg_Num(EX_WB_Write_Reg_Num),
    .EX_WB_ALUResult(EX_WB_ALUResult),
    .Read_Reg_Num1(Read_Reg_Num1), .Read_Reg_Num2(Read_Reg_Num2),
    .Read_Data1(rd1_w), .Read_Data2(rd2_w),
    .ID_EX_Rs1(ID_EX_Rs1), .ID_EX_Rs2(ID_EX_Rs2),
    .ID_EX_Data1(ID_EX_Data1), .ID_EX_Data2(ID_EX_Data2),
    .EX_Operand1(op1_w), .EX_Operand2(op2_w),
    .WB_Count(wb_count_w)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wb(input logic we, input logic [2:0] num, input logic [7:0] data);
    EX_WB_RegWrite      = we;
    EX_WB_Write_Reg_Num = num;
    EX_WB_ALUResult     = data;
  endtask

  initial begin
    Reset = 1'b0;
    wb(1'b0, 3'd0, 8'h00);
    Read_Reg_Num1 = 3'd0; Read_Reg_Num2 = 3'd0;
    ID_EX_Rs1 = 3'd0; ID_EX_Rs2 = 3'd0;
    ID_EX_Data1 = 8'h00; ID_EX_Data2 = 8'h00;
    tick(); tick();
    Reset = 1'b1;
    tick();

    Read_Reg_Num1 = 3'd3; Read_Reg_Num2 = 3'd5; #1;
    chk("rst_rd1", Read_Data1, 8'h00);
    chk("rst_rd2", Read_Data2, 8'h00);
    chk("rst_cnt", WB_Count, 16'd0);

    // Commit R3 = A5, read it from the array next cycle
    wb(1'b1, 3'd3, 8'hA5);
    tick();
    wb(1'b0, 3'd0, 8'h00); #1;
    chk("r3_rd1", Read_Data1, 8'hA5);
    chk("r3_cnt", WB_Count, 16'd1);

    // Same-cycle write-through on port 2, port 1 unaffected
    wb(1'b1, 3'd5, 8'h3C); #1;
    chk("byp_rd2", Read_Data2, 8'h3C);
    chk("byp_rd1", Read_Data1, 8'hA5);
    tick();
    wb(1'b0, 3'd0, 8'h00); #1;
    chk("r5_rd2", Read_Data2, 8'h3C);
    chk("r5_cnt", WB_Count, 16'd2);

    // Both ports on the same bypass
    Read_Reg_Num1 = 3'd6; Read_Reg_Num2 = 3'd6;
    wb(1'b1, 3'd6, 8'h5A); #1;
    chk("byp_both1", Read_Data1, 8'h5A);
    chk("byp_both2", Read_Data2, 8'h5A);
    tick();
    wb(1'b0, 3'd0, 8'h00); #1;
    chk("r6_cnt", WB_Count, 16'd3);

    // R0 write is discarded, not forwarded and not counted
    Read_Reg_Num1 = 3'd0; ID_EX_Rs1 = 3'd0; ID_EX_Data1 = 8'h22;
    wb(1'b1, 3'd0, 8'hFF); #1;
    chk("r0_rd1", Read_Data1, 8'h00);
    chk("r0_fwd", EX_Operand1, 8'h22);
    tick();
    wb(1'b0, 3'd0, 8'h00); #1;
    chk("r0_rd_after", Read_Data1, 8'h00);
    chk("r0_cnt", WB_Count, 16'd3);

    // Forwarding to both operands, then no RegWrite
    ID_EX_Rs1 = 3'd2; ID_EX_Rs2 = 3'd2; ID_EX_Data1 = 8'h11; ID_EX_Data2 = 8'h11;
    wb(1'b1, 3'd2, 8'h77); #1;
    chk("fwd_op1", EX_Operand1, 8'h77);
    chk("fwd_op2", EX_Operand2, 8'h77);
    EX_WB_RegWrite = 1'b0; #1;
    chk("nofwd_op1", EX_Operand1, 8'h11);
    chk("nofwd_op2", EX_Operand2, 8'h11);
    // Only one operand matches
    ID_EX_Rs2 = 3'd4; ID_EX_Data2 = 8'h44; EX_WB_RegWrite = 1'b1; #1;
    chk("fwd1_only_op1", EX_Operand1, 8'h77);
    chk("fwd1_only_op2", EX_Operand2, 8'h44);
    EX_WB_RegWrite = 1'b0;
    tick();
    chk("nocommit_cnt", WB_Count, 16'd3);

    // Async reset with a pending write: state clears with no clock edge
    Read_Reg_Num1 = 3'd3; Read_Reg_Num2 = 3'd5;
    wb(1'b1, 3'd7, 8'h99); #1;
    Reset = 1'b0; #1;
    chk("arst_rd1", Read_Data1, 8'h00);
    chk("arst_rd2", Read_Data2, 8'h00);
    chk("arst_cnt", WB_Count, 16'd0);
    tick();
    wb(1'b0, 3'd0, 8'h00);
    Reset = 1'b1;
    Read_Reg_Num1 = 3'd7; #1;
    chk("arst_r7_lost", Read_Data1, 8'h00);
    chk("arst_cnt_hold", WB_Count, 16'd0);

    // Sixteen commits: the 4-bit counter wraps to zero
    for (int i = 0; i < 16; i++) begin
      wb(1'b1, 3'(i % 7 + 1), 8'(i));
      tick();
      if (i == 14) chk("wrap_cnt15", wb_count_w, 4'd15);
    end
    wb(1'b0, 3'd0, 8'h00); #1;
    chk("wrap_cnt0", wb_count_w, 4'd0);
    chk("wide_cnt16", WB_Count, 16'd16);
    // Last write to R2 was i=15 (15%7+1 = 2)
    Read_Reg_Num1 = 3'd2; #1;
    chk("wrap_r2", Read_Data1, 8'h0F);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
